// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - data-memory port arbiter between CPU MEM stage and serial debug unit
// CPU owns the port by default; the SDU is granted when the CPU is idle/halted or has refused it MAX_WAIT times.
module dm_port_arbiter #(
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clk_cpu,
   input  logic             rst,
   input  logic             cpu_re,
   input  logic             cpu_we,
   input  logic [31:0]      cpu_addr,
   input  logic [31:0]      cpu_wdata,
   output logic [31:0]      cpu_rdata,
   output logic             cpu_stall,
   input  logic             cpu_halted,
   input  logic             dbg_req,
   input  logic             dbg_we,
   input  logic [31:0]      dbg_addr,
   input  logic [31:0]      dbg_wdata,
   output logic             dbg_ack,
   output logic [31:0]      dbg_rdata,
   output logic [31:0]      dm_addr,
   output logic [31:0]      dm_wdata,
   output logic             dm_we,
   input  logic [31:0]      dm_rdata,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

   typedef enum logic {IDLE, ACK} state_t;

   state_t            state;
   logic [WAIT_W-1:0] wait_cnt;
   logic              cpu_acc;
   logic              starve;
   logic              grant;

   assign cpu_acc = cpu_re | cpu_we;
   assign starve  = (32'(wait_cnt) >= 32'(MAX_WAIT));
   assign grant   = (state == IDLE) & dbg_req & (cpu_halted | ~cpu_acc | starve);

   // A granted SDU access takes the whole port; any CPU store in that cycle is dropped.
   assign dm_addr   = grant ? dbg_addr  : cpu_addr;
   assign dm_wdata  = grant ? dbg_wdata : cpu_wdata;
   assign dm_we     = ~rst & (grant ? dbg_we : cpu_we);
   assign cpu_stall = ~rst & grant & cpu_acc & ~cpu_halted;
   assign cpu_rdata = dm_rdata;

   always_ff @(posedge clk_cpu) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         dbg_ack   <= 1'b0;
         dbg_rdata <= '0;
         stall_cnt <= '0;
      end else begin
         if (cpu_stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         case (state)
            IDLE: begin
               if (grant) begin
                  if (!dbg_we)
                     dbg_rdata <= dm_rdata;
                  dbg_ack  <= 1'b1;
                  wait_cnt <= '0;
                  state    <= ACK;
               end else if (dbg_req) begin
                  if (wait_cnt != '1)
                     wait_cnt <= wait_cnt + 1'b1;
               end else begin
                  wait_cnt <= '0;
               end
            end
            ACK: begin
               // Ack is held until the SDU drops its request; the CPU keeps the port meanwhile.
               if (!dbg_req) begin
                  dbg_ack <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb/tb_dm_port_arbiter.sv - self-checking bench for dm_port_arbiter
// Directed scenarios then randomized traffic, all compared against a transaction-level model.
module tb_dm_port_arbiter;

   localparam int MAX_WAIT = 4;
   localparam int CNT_W    = 16;

   logic             clk_cpu = 1'b0;
   logic             rst = 1'b1;
   logic             cpu_re = 1'b0, cpu_we = 1'b0, cpu_halted = 1'b0;
   logic [31:0]      cpu_addr = '0, cpu_wdata = '0;
   logic [31:0]      cpu_rdata;
   logic             cpu_stall;
   logic             dbg_req = 1'b0, dbg_we = 1'b0;
   logic [31:0]      dbg_addr = '0, dbg_wdata = '0;
   logic             dbg_ack;
   logic [31:0]      dbg_rdata;
   logic [31:0]      dm_addr, dm_wdata, dm_rdata;
   logic             dm_we;
   logic [CNT_W-1:0] stall_cnt;

   dm_port_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
      .clk_cpu(clk_cpu), .rst(rst),
      .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_halted(cpu_halted),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_we(dm_we), .dm_rdata(dm_rdata),
      .stall_cnt(stall_cnt)
   );

   always #5 clk_cpu = ~clk_cpu;

   function automatic logic [31:0] init_word(int i);
      return (i == 16) ? 32'hDEADBEEF : (32'hA5000000 | 32'(i));
   endfunction

   // Data memory: async read, synchronous write, reloaded with a known pattern on reset.
   logic [31:0] dm [0:255];
   assign dm_rdata = dm[dm_addr[7:0]];
   always @(posedge clk_cpu) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) dm[i] <= init_word(i);
      end else if (dm_we) begin
         dm[dm_addr[7:0]] <= dm_wdata;
      end
   end

   int checks = 0;
   int failures = 0;

   // Reference model: one outstanding SDU transaction, refusal count, stall total, memory image.
   logic [31:0] ref_mem [0:255];
   bit          m_busy = 0;
   bit          m_ack = 0;
   int          m_wait = 0;
   int          m_stall = 0;
   logic [31:0] m_rdata = '0;
   bit          last_win = 0;
   logic        obs_stall = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      bit acc, win, stall_exp;
      @(negedge clk_cpu);
      acc       = cpu_re | cpu_we;
      win       = !rst && !m_busy && dbg_req && (cpu_halted || !acc || m_wait >= MAX_WAIT);
      stall_exp = win && acc && !cpu_halted;
      obs_stall = cpu_stall;
      chk("cpu_stall", {31'b0, cpu_stall}, {31'b0, stall_exp});
      chk("dm_we", {31'b0, dm_we}, rst ? 32'd0 : {31'b0, win ? dbg_we : cpu_we});
      if (!rst) begin
         chk("dm_addr", dm_addr, win ? dbg_addr : cpu_addr);
         chk("dm_wdata", dm_wdata, win ? dbg_wdata : cpu_wdata);
         if (!win) chk("cpu_rdata", cpu_rdata, ref_mem[cpu_addr[7:0]]);
      end
      chk("dbg_ack", {31'b0, dbg_ack}, {31'b0, m_ack});
      chk("dbg_rdata", dbg_rdata, m_rdata);
      chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
      @(posedge clk_cpu);
      if (rst) begin
         for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
         m_busy = 0; m_wait = 0; m_stall = 0; m_rdata = '0;
      end else if (win) begin
         if (dbg_we) ref_mem[dbg_addr[7:0]] = dbg_wdata;
         else        m_rdata = ref_mem[dbg_addr[7:0]];
         if (stall_exp && m_stall < (1 << CNT_W) - 1) m_stall++;
         m_busy = 1;
         m_wait = 0;
      end else begin
         if (cpu_we) ref_mem[cpu_addr[7:0]] = cpu_wdata;
         if (m_busy) begin
            if (!dbg_req) m_busy = 0;
         end else begin
            m_wait = dbg_req ? ((m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT) : 0;
         end
      end
      m_ack    = m_busy;
      last_win = win;
      #1;
   endtask

   initial begin
      #1;
      tick(); tick();
      chk("reset_ack", {31'b0, dbg_ack}, 32'd0);
      chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
      rst = 1'b0;
      tick();

      // 1: idle CPU, SDU read of 0x10
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
      tick();
      chk("t1_grant", {31'b0, last_win}, 32'd1);
      chk("t1_no_stall", {31'b0, obs_stall}, 32'd0);
      chk("t1_ack", {31'b0, dbg_ack}, 32'd1);
      chk("t1_rdata", dbg_rdata, 32'hDEADBEEF);
      dbg_req = 1'b0;
      tick(); tick();

      // 2: CPU loads every cycle, SDU held off for MAX_WAIT cycles
      cpu_re = 1'b1; cpu_addr = 32'h4;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
      for (int i = 0; i <= MAX_WAIT; i++) begin
         tick();
         chk($sformatf("t2_stall_cyc%0d", i), {31'b0, obs_stall}, (i == MAX_WAIT) ? 32'd1 : 32'd0);
      end
      chk("t2_ack", {31'b0, dbg_ack}, 32'd1);
      chk("t2_stall_cnt", 32'(stall_cnt), 32'd1);
      dbg_req = 1'b0;
      tick();
      cpu_re = 1'b0;

      // 3: colliding CPU store and SDU write to 0x8
      cpu_we = 1'b1; cpu_addr = 32'h8; cpu_wdata = 32'h1111;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h8; dbg_wdata = 32'h2222;
      for (int i = 0; i <= MAX_WAIT; i++) tick();
      chk("t3_stall", {31'b0, obs_stall}, 32'd1);
      chk("t3_mem", dm[8], 32'h2222);
      cpu_we = 1'b0; dbg_req = 1'b0;
      tick();

      // 4: halted CPU, immediate grant without stall
      cpu_halted = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h9; cpu_wdata = 32'h3333;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'hA; dbg_wdata = 32'h4444;
      tick();
      chk("t4_grant", {31'b0, last_win}, 32'd1);
      chk("t4_no_stall", {31'b0, obs_stall}, 32'd0);
      chk("t4_mem", dm[10], 32'h4444);
      cpu_we = 1'b0; cpu_halted = 1'b0; dbg_req = 1'b0;
      tick();

      // 5: reset while in ACK, then a new request
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h10;
      tick();
      rst = 1'b1; cpu_we = 1'b1;
      tick();
      chk("t5_ack_lost", {31'b0, dbg_ack}, 32'd0);
      chk("t5_stall_cnt", 32'(stall_cnt), 32'd0);
      rst = 1'b0; cpu_we = 1'b0;
      tick();
      chk("t5_reserved", {31'b0, dbg_ack}, 32'd1);
      dbg_req = 1'b0;
      tick();

      // 6: request held through ACK
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h3;
      tick();
      cpu_we = 1'b1; cpu_addr = 32'h5; cpu_wdata = 32'h5555;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_ack_held", {31'b0, dbg_ack}, 32'd1);
         chk("t6_no_regrant", {31'b0, last_win}, 32'd0);
      end
      dbg_req = 1'b0;
      tick();
      chk("t6_ack_fall", {31'b0, dbg_ack}, 32'd0);
      cpu_we = 1'b0;

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         cpu_re     = ($urandom_range(0, 9) < 5);
         cpu_we     = !cpu_re && ($urandom_range(0, 9) < 4);
         cpu_addr   = 32'($urandom_range(0, 31));
         cpu_wdata  = $urandom;
         cpu_halted = ($urandom_range(0, 9) == 0);
         rst        = ($urandom_range(0, 99) == 0);
         if (!dbg_req) begin
            if ($urandom_range(0, 2) == 0) begin
               dbg_req   = 1'b1;
               dbg_we    = $urandom_range(0, 1) == 1;
               dbg_addr  = 32'($urandom_range(0, 31));
               dbg_wdata = $urandom;
            end
         end else if (dbg_ack || $urandom_range(0, 30) == 0) begin
            dbg_req = 1'b0;
         end
         tick();
      end
      rst = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
